// File: rtl/regfile_2r1w_pkg.sv
// Shared MIPS32 datapath constants for the register file and its read ports.
// Build option: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
package regfile_2r1w_pkg;

  localparam int unsigned REG_NUM_W = 5;
  localparam int unsigned WORD_W    = 32;
  localparam logic [REG_NUM_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_NUM_W-1:0] reg_num_t;
  typedef logic [WORD_W-1:0]    word_t;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Register-file access bundle: two read address/data pairs plus the write port.
interface regfile_2r1w_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);

  logic [ADDR_W-1:0] rna;
  logic [ADDR_W-1:0] rnb;
  logic [DATA_W-1:0] qa;
  logic [DATA_W-1:0] qb;
  logic [ADDR_W-1:0] wn;
  logic [DATA_W-1:0] d;
  logic              we;

  modport master (
    output rna, rnb, wn, d, we,
    input  qa, qb
  );

  modport slave (
    input  rna, rnb, wn, d, we,
    output qa, qb
  );

endinterface

// File: rtl/regfile_2r1w_rdport.sv
// One combinational read port: $0 reads as zero, optional forwarding of the
// in-flight write when REGFILE_BYPASS_EN is defined.
module regfile_rdport #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rn_i,
  input  logic [DATA_W-1:0] regs_i [1:(2**ADDR_W)-1],
  input  logic              byp_we_i,
  input  logic [ADDR_W-1:0] byp_wn_i,
  input  logic [DATA_W-1:0] byp_d_i,
  output logic [DATA_W-1:0] q_o
);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    q_o = '0;
    if (rn_i != '0) begin
      // Write data wins over stored data so WB results reach ID in one cycle.
      if (byp_we_i && (rn_i == byp_wn_i)) begin
        q_o = byp_d_i;
      end else begin
        q_o = regs_i[rn_i];
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_we_i, byp_wn_i, byp_d_i};

  always_comb begin
    q_o = '0;
    if (rn_i != '0) begin
      q_o = regs_i[rn_i];
    end
  end
`endif

endmodule

// File: rtl/regfile_2r1w.sv
// 32 x 32 MIPS32 register file: two asynchronous reads, one rising-edge write,
// $0 hardwired to zero. Build option: REGFILE_BYPASS_EN (write forwarding).
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_W,
  parameter int unsigned ADDR_W = REG_NUM_W
) (
  input logic           clk,
  input logic           clrn,
  regfile_2r1w_if.slave rf
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // No storage for $0: the array starts at entry 1.
  logic [DATA_W-1:0] regs_q [1:DEPTH-1];
  logic [DATA_W-1:0] regs_d [1:DEPTH-1];
  logic              wr_en;

  assign wr_en = rf.we && (rf.wn != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[rf.wn] = rf.d;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Forwarding is qualified by clrn so reads stay zero throughout reset.
  logic byp_we;
  assign byp_we = rf.we && clrn;

  regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport_a (
    .rn_i     (rf.rna),
    .regs_i   (regs_q),
    .byp_we_i (byp_we),
    .byp_wn_i (rf.wn),
    .byp_d_i  (rf.d),
    .q_o      (rf.qa)
  );

  regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport_b (
    .rn_i     (rf.rnb),
    .regs_i   (regs_q),
    .byp_we_i (byp_we),
    .byp_wn_i (rf.wn),
    .byp_d_i  (rf.d),
    .q_o      (rf.qb)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w; expectations follow the
// REGFILE_BYPASS_EN setting of the build.
module tb_regfile_2r1w;

  logic clk;
  logic clrn;
  int   checks;
  int   failures;

  regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5)) rf ();

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk  (clk),
    .clrn (clrn),
    .rf   (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] n, input logic [31:0] v);
    rf.we = 1'b1;
    rf.wn = n;
    rf.d  = v;
    tick();
    rf.we = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clrn  = 1'b0;
    rf.we = 1'b1;
    rf.wn = 5'd5;
    rf.d  = 32'hDEADBEEF;
    rf.rna = 5'd5;
    rf.rnb = 5'd5;

    // 1: reset with a pending write to r5
    repeat (2) tick();
    check("reset_qa_r5_in_reset", rf.qa, 32'h0);
    check("reset_qb_r5_in_reset", rf.qb, 32'h0);
    clrn  = 1'b1;
    rf.we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rf.rna = 5'(i);
      rf.rnb = 5'(i);
      #1;
      check($sformatf("reset_qa_r%0d", i), rf.qa, 32'h0);
      check($sformatf("reset_qb_r%0d", i), rf.qb, 32'h0);
    end

    // 2: basic write / dual read
    write_reg(5'd8, 32'h12345678);
    rf.rna = 5'd8;
    rf.rnb = 5'd8;
    #1;
    check("basic_qa_r8", rf.qa, 32'h12345678);
    check("basic_qb_r8", rf.qb, 32'h12345678);
    rf.rnb = 5'd5;
    #1;
    check("basic_qb_r5_untouched", rf.qb, 32'h0);

    // 3: $0 ignores writes and never forwards
    rf.rna = 5'd0;
    rf.rnb = 5'd0;
    rf.we  = 1'b1;
    rf.wn  = 5'd0;
    rf.d   = 32'hFFFFFFFF;
    #1;
    check("zero_qa_before_edge", rf.qa, 32'h0);
    check("zero_qb_before_edge", rf.qb, 32'h0);
    tick();
    rf.we = 1'b0;
    #1;
    check("zero_qa_after_edge", rf.qa, 32'h0);

    // 4: we=0 gates the write
    write_reg(5'd3, 32'hA5A5A5A5);
    rf.we = 1'b0;
    rf.wn = 5'd3;
    rf.d  = 32'h0;
    tick();
    rf.rna = 5'd3;
    #1;
    check("we_gate_r3", rf.qa, 32'hA5A5A5A5);

    // 5: same-cycle read-after-write
    write_reg(5'd9, 32'h1);
    rf.we  = 1'b1;
    rf.wn  = 5'd9;
    rf.d   = 32'h2;
    rf.rna = 5'd9;
    rf.rnb = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("raw_qa_before_edge", rf.qa, 32'h2);
`else
    check("raw_qa_before_edge", rf.qa, 32'h1);
`endif
    check("raw_qb_other_reg", rf.qb, 32'hA5A5A5A5);
    tick();
    rf.we = 1'b0;
    #1;
    check("raw_qa_after_edge", rf.qa, 32'h2);
    rf.we  = 1'b1;
    rf.wn  = 5'd0;
    rf.d   = 32'h5;
    rf.rna = 5'd0;
    #1;
    check("raw_zero_no_forward", rf.qa, 32'h0);
    rf.we = 1'b0;

    // 6: asynchronous reset between edges, write blocked while clrn=0
    write_reg(5'd31, 32'h7);
    rf.rna = 5'd31;
    rf.rnb = 5'd8;
    #1;
    check("async_r31_before", rf.qa, 32'h7);
    #2;
    clrn = 1'b0;
    #1;
    check("async_qa_r31_immediate", rf.qa, 32'h0);
    check("async_qb_r8_immediate", rf.qb, 32'h0);
    rf.we = 1'b1;
    rf.wn = 5'd31;
    rf.d  = 32'hFFFF0000;
    #1;
    check("async_no_forward_in_reset", rf.qa, 32'h0);
    tick();
    check("async_write_blocked", rf.qa, 32'h0);
    rf.we = 1'b0;
    clrn  = 1'b1;
    #1;
    check("async_after_release", rf.qa, 32'h0);
    write_reg(5'd31, 32'h55);
    #1;
    check("write_after_release", rf.qa, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
